alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational `alu` instance between NREQ requesters (e.g. execute stage, address-gen, CSR unit).
//  Grants one operation per cycle using round-robin arbitration.
//  Registers the result into a one-entry response buffer with valid/ready backpressure.
//  Tags each response with the requester index.
// PARAMETERS
//  DWIDTH  32  operand/result width, passed to the alu instance
//  NREQ    2   number of requesters, >=2
//  IDW     $clog2(NREQ)  requester-id width, derived (localparam), not overridable
//  CNTW    16  perf-counter width; used only with ALU_ARB_PERF_EN
// PORTS
//  clk        in   1             clock, all logic on rising edge
//  rst        in   1             synchronous reset, active-high
//  req_valid  in   NREQ          per-requester operation valid
//  req_ready  out  NREQ          per-requester accept; at most one bit set
//  req_src1   in   NREQ*DWIDTH   packed [NREQ-1:0][DWIDTH-1:0] operand 1
//  req_src2   in   NREQ*DWIDTH   packed operand 2
//  req_sel    in   NREQ*aluop_sel_t  per-requester operation select
//  rsp_valid  out  1             response buffer holds a result
//  rsp_ready  in   1             consumer accepts the response
//  rsp_res    out  DWIDTH        registered alu result
//  rsp_is_0   out  1             registered result-is-zero flag
//  rsp_id     out  IDW           index of the requester that issued the op
//  rsp_err    out  1             req_sel was not a legal operation
//  perf_clr   in   1             clear grant counters (ALU_ARB_PERF_EN only)
//  grant_cnt  out  NREQ*CNTW     per-requester accepted-op counters (ALU_ARB_PERF_EN only)
// BEHAVIOUR
//  - Issue slot free when !rsp_valid || rsp_ready.
//  - When the slot is free and any req_valid is set, grant exactly one requester.
//    Search starts at (last+1) mod NREQ and takes the first valid requester.
//  - req_ready[g] is high only for the grant; all ready bits are 0 when the slot is not free or when rst=1.
//  - Ready is a combinational function of valid, pointer and slot state.
//    A requester's valid must not depend on its ready.
//    Once raised, valid and operands must hold until ready.
//  - Handshake = req_valid[i] && req_ready[i].
//    On the next edge: rsp_valid<=1, rsp_res/rsp_is_0 <= alu output, rsp_id<=i, last<=i.
//  - Latency is 1 cycle. Throughput is 1 op/cycle while rsp_ready is held high.
//  - Backpressure: while rsp_valid && !rsp_ready, all rsp_* outputs hold stable and no grant is issued.
//  - Drain: rsp_ready && !any handshake -> rsp_valid<=0. Accept and issue in the same cycle are allowed.
//  - Illegal sel (not one of AND, OR, ADD, SUB, XOR, SLT, SLTU, SLL, SRL, SRA):
//    the op is still accepted; rsp_res<=0, rsp_is_0<=1, rsp_err<=1. X is never propagated.
//  - Legal op: rsp_err<=0.
//  - Pointer `last` updates only on a handshake. Wrap-around is NREQ-1 -> 0.
//    A single active requester gets back-to-back grants.
//  - Reset: rsp_valid=0, rsp_res=0, rsp_is_0=0, rsp_id=0, rsp_err=0, last=NREQ-1 (requester 0 first).
//    Reset mid-operation discards any buffered response. No handshake occurs in a reset cycle.
// CONFIGURATION
//  ALU_ARB_PERF_EN defined:
//    - Adds the perf_clr and grant_cnt ports.
//    - grant_cnt[i] increments on each handshake of requester i and saturates at all-ones.
//    - Counters reset to 0 on rst or perf_clr; perf_clr has priority over the increment.
//  ALU_ARB_PERF_EN undefined:
//    - The perf_clr and grant_cnt ports and the counters do not exist.
//    - Arbitration behaviour is identical.
// STRUCTURE
//  - typedefs_pkg supplies aluop_sel_t.
//  - Add to typedefs_pkg: function is_legal_aluop(aluop_sel_t), shared with the decoder.
//  - One sub-module: a single instance of the existing `alu` (DWIDTH passed through), fed by the granted requester's mux.
//  - Round-robin picker and response register stay inline.
// TESTING
//  1 Reset: assert rst with req_valid=2'b11 -> req_ready=0, rsp_valid=0; the first grant after reset goes to req 0.
//  2 Fairness: both valid, rsp_ready=1 -> grants alternate 0,1,0,1.
//    Each rsp_id matches its grant and arrives one cycle later.
//    ADD 5+3 gives rsp_res=8; SUB 3-3 gives rsp_res=0, rsp_is_0=1.
//  3 Backpressure: rsp_ready=0 for 3 cycles with rsp_valid=1 -> rsp_* stable and req_ready=0.
//    On release, the same-cycle accept plus new issue leaves no bubble.
//  4 Illegal sel: encoding outside the enum -> accepted; rsp_res=0, rsp_err=1, rsp_is_0=1.
//    A following SRA of 0x80000000 by 4 -> rsp_res=0xF8000000, rsp_err=0.
//  5 Reset mid-stream: rst while rsp_valid=1 and stalled -> the response is dropped and rsp_valid=0 next cycle.
//  6 ALU_ARB_PERF_EN: 10 grants to req 1 -> grant_cnt[1]=10.
//    perf_clr with a simultaneous grant -> 0. CNTW=4 with 20 grants -> saturates at 15.

Source files
------------

// File: rtl/typedefs_pkg.sv
// Shared type definitions for the ALU datapath.
//   aluop_sel_t     : 4-bit ALU operation select; encodings 10..15 are illegal
//   is_legal_aluop(): true for the ten defined operations, shared with the decoder
package typedefs_pkg;

  localparam int ALUOP_W = 4;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } aluop_sel_t;

  function automatic logic is_legal_aluop(aluop_sel_t sel);
    case (sel)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU.
//   a, b  in  DWIDTH   operands (signed views used for SLT/SRA)
//   sel   in  aluop_sel_t operation select
//   res   out DWIDTH   result; 0 for an illegal select (never X)
//   is_0  out 1        result-is-zero flag
import typedefs_pkg::*;

module alu #(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  input  aluop_sel_t        sel,
  output logic [DWIDTH-1:0] res,
  output logic              is_0
);

  localparam int SHW = $clog2(DWIDTH);

  logic signed [DWIDTH-1:0] a_s;
  logic signed [DWIDTH-1:0] b_s;
  logic        [SHW-1:0]    shamt;

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[SHW-1:0];

  always_comb begin
    res = '0;
    case (sel)
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_XOR:  res = a ^ b;
      ALU_SLT:  res = {{(DWIDTH-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: res = {{(DWIDTH-1){1'b0}}, (a < b)};
      ALU_SLL:  res = a << shamt;
      ALU_SRL:  res = a >> shamt;
      ALU_SRA:  res = a_s >>> shamt;
      default:  res = '0;
    endcase
  end

  assign is_0 = (res == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters, with a
// one-entry registered response buffer (valid/ready) tagged by requester id.
// Optional feature macro: ALU_ARB_PERF_EN adds perf_clr / grant_cnt
// (per-requester saturating accepted-op counters).
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    per-requester handshake (ready is one-hot or zero)
//   req_src1/req_src2      packed per-requester operands
//   req_sel                per-requester ALU operation select
//   rsp_valid/rsp_ready    response handshake
//   rsp_res/rsp_is_0       registered ALU result and zero flag
//   rsp_id/rsp_err         issuing requester index, illegal-select flag
//   perf_clr/grant_cnt     counter clear and counters (ALU_ARB_PERF_EN only)
import typedefs_pkg::*;

module alu_arbiter #(
  parameter  int DWIDTH = 32,
  parameter  int NREQ   = 2,
  parameter  int CNTW   = 16,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ-1:0][DWIDTH-1:0]  req_src1,
  input  logic [NREQ-1:0][DWIDTH-1:0]  req_src2,
  input  aluop_sel_t [NREQ-1:0]        req_sel,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DWIDTH-1:0]            rsp_res,
  output logic                         rsp_is_0,
  output logic [IDW-1:0]               rsp_id,
  output logic                         rsp_err
`ifdef ALU_ARB_PERF_EN
  ,
  input  logic                         perf_clr,
  output logic [NREQ-1:0][CNTW-1:0]    grant_cnt
`endif
);

  logic                slot_free_p0;
  logic                any_vld_p0;
  logic                hs_p0;
  int                  cand_p0;
  logic [IDW-1:0]      gnt_id_p0;
  logic [NREQ-1:0]     gnt_oh_p0;
  logic [DWIDTH-1:0]   src1_p0;
  logic [DWIDTH-1:0]   src2_p0;
  aluop_sel_t          sel_p0;
  logic [DWIDTH-1:0]   alu_res_p0;
  logic                alu_is0_p0;

  logic                vld_p1;
  logic [DWIDTH-1:0]   rsp_res_p1;
  logic                rsp_is0_p1;
  logic [IDW-1:0]      rsp_id_p1;
  logic                rsp_err_p1;
  logic [IDW-1:0]      last_p1;

  // ---- stage p0: round-robin pick, operand mux, ALU ----
  assign slot_free_p0 = !vld_p1 || rsp_ready;

  always_comb begin
    any_vld_p0 = 1'b0;
    gnt_id_p0  = '0;
    cand_p0    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_p0 = (int'(last_p1) + k) % NREQ;
      if (!any_vld_p0 && req_valid[IDW'(cand_p0)]) begin
        any_vld_p0 = 1'b1;
        gnt_id_p0  = IDW'(cand_p0);
      end
    end
  end

  assign hs_p0 = slot_free_p0 && any_vld_p0 && !rst;

  always_comb begin
    gnt_oh_p0 = '0;
    if (hs_p0) gnt_oh_p0[gnt_id_p0] = 1'b1;
  end

  assign req_ready = gnt_oh_p0;
  assign src1_p0   = req_src1[gnt_id_p0];
  assign src2_p0   = req_src2[gnt_id_p0];
  assign sel_p0    = req_sel[gnt_id_p0];

  alu #(
    .DWIDTH (DWIDTH)
  ) u_alu (
    .a    (src1_p0),
    .b    (src2_p0),
    .sel  (sel_p0),
    .res  (alu_res_p0),
    .is_0 (alu_is0_p0)
  );

  // ---- stage p1: response buffer and round-robin pointer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      rsp_res_p1 <= '0;
      rsp_is0_p1 <= 1'b0;
      rsp_id_p1  <= '0;
      rsp_err_p1 <= 1'b0;
      last_p1    <= IDW'(NREQ - 1);
    end else if (hs_p0) begin
      vld_p1     <= 1'b1;
      rsp_res_p1 <= alu_res_p0;
      rsp_is0_p1 <= alu_is0_p0;
      rsp_id_p1  <= gnt_id_p0;
      rsp_err_p1 <= !is_legal_aluop(sel_p0);
      last_p1    <= gnt_id_p0;
    end else if (rsp_ready) begin
      vld_p1     <= 1'b0;
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_res   = rsp_res_p1;
  assign rsp_is_0  = rsp_is0_p1;
  assign rsp_id    = rsp_id_p1;
  assign rsp_err   = rsp_err_p1;

`ifdef ALU_ARB_PERF_EN
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_oh_p0[i]) grant_cnt[i] <= sat_inc(grant_cnt[i]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import typedefs_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        is0;
    logic        err;
    int          id;
  } exp_t;

  typedef struct {
    int          req;
    aluop_sel_t  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        is0;
    logic        err;
  } vec_t;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_src1;
  logic [1:0][31:0] req_src2;
  aluop_sel_t [1:0] req_sel;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_res;
  logic             rsp_is_0;
  logic [0:0]       rsp_id;
  logic             rsp_err;
  logic             perf_clr;
  logic [1:0][3:0]  grant_cnt;

  alu_arbiter #(
    .DWIDTH (32),
    .NREQ   (2),
    .CNTW   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_is_0  (rsp_is_0),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_clr  (perf_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t cur_exp[2];
  exp_t sbq[$];
  logic m_vld;
  int   m_last;
  int   m_cnt[2];
  int   last_grant;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t ref_alu(aluop_sel_t s, logic [31:0] a, logic [31:0] b);
    exp_t e;
    e.id  = 0;
    e.err = 1'b0;
    case (s)
      ALU_AND:  e.res = a & b;
      ALU_OR:   e.res = a | b;
      ALU_ADD:  e.res = a + b;
      ALU_SUB:  e.res = a - b;
      ALU_XOR:  e.res = a ^ b;
      ALU_SLT:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: e.res = (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  e.res = a << b[4:0];
      ALU_SRL:  e.res = a >> b[4:0];
      ALU_SRA:  e.res = $unsigned($signed(a) >>> b[4:0]);
      default: begin
        e.res = 32'd0;
        e.err = 1'b1;
      end
    endcase
    e.is0 = (e.res == 32'd0);
    return e;
  endfunction

  task automatic drive(input int i, input aluop_sel_t s, input logic [31:0] a,
                       input logic [31:0] b, input exp_t e);
    req_sel[i]   = s;
    req_src1[i]  = a;
    req_src2[i]  = b;
    cur_exp[i]   = e;
    req_valid[i] = 1'b1;
  endtask

  // Called at a negedge after inputs are driven; checks, advances the model
  // to the next edge and returns at the following negedge.
  task automatic cycle();
    logic [1:0] er;
    int         g;
    int         c;
    exp_t       e;
    exp_t       f;
    #1;
    er = 2'b00;
    g  = -1;
    if (!rst && (!m_vld || rsp_ready)) begin
      for (int k = 1; k <= 2; k++) begin
        c = (m_last + k) % 2;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("rsp_valid", rsp_valid, m_vld);
`ifdef ALU_ARB_PERF_EN
    chk("grant_cnt0", grant_cnt[0], m_cnt[0]);
    chk("grant_cnt1", grant_cnt[1], m_cnt[1]);
`endif
    if (m_vld) begin
      if (sbq.size() == 0) begin
        chk("sb_nonempty", 64'd0, 64'd1);
      end else begin
        f = sbq[0];
        chk("rsp_res", rsp_res, f.res);
        chk("rsp_is_0", rsp_is_0, f.is0);
        chk("rsp_id", rsp_id, f.id);
        chk("rsp_err", rsp_err, f.err);
        if (rsp_ready) void'(sbq.pop_front());
      end
    end
    last_grant = g;
    if (rst) begin
      m_vld  = 1'b0;
      m_last = 1;
      sbq.delete();
    end else if (g >= 0) begin
      e    = cur_exp[g];
      e.id = g;
      sbq.push_back(e);
      m_vld  = 1'b1;
      m_last = g;
    end else if (rsp_ready) begin
      m_vld = 1'b0;
    end
    if (rst || perf_clr) begin
      m_cnt[0] = 0;
      m_cnt[1] = 0;
    end else if (g >= 0) begin
      m_cnt[g] = (m_cnt[g] == 15) ? 15 : m_cnt[g] + 1;
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(int r, aluop_sel_t s, logic [31:0] a, logic [31:0] b,
                              logic [31:0] res, logic is0, logic err);
    vec_t v;
    v.req = r; v.sel = s; v.a = a; v.b = b; v.res = res; v.is0 = is0; v.err = err;
    return v;
  endfunction

  initial begin
    int         order[4];
    aluop_sel_t rs;
    exp_t       e;

    tbl[0]  = mk(0, ALU_ADD,  32'd5,         32'd3,         32'd8,         1'b0, 1'b0);
    tbl[1]  = mk(1, ALU_SUB,  32'd3,         32'd3,         32'd0,         1'b1, 1'b0);
    tbl[2]  = mk(0, ALU_AND,  32'hF0F0_0000, 32'hFF00_FF00, 32'hF000_0000, 1'b0, 1'b0);
    tbl[3]  = mk(1, ALU_OR,   32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0);
    tbl[4]  = mk(0, ALU_XOR,  32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 1'b0);
    tbl[5]  = mk(1, ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b0);
    tbl[6]  = mk(1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0);
    tbl[7]  = mk(0, ALU_SLL,  32'd1,         32'd31,        32'h8000_0000, 1'b0, 1'b0);
    tbl[8]  = mk(0, ALU_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1'b0);
    tbl[9]  = mk(1, aluop_sel_t'(4'hF), 32'h1234_5678, 32'd9, 32'd0,       1'b1, 1'b1);
    tbl[10] = mk(1, ALU_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1'b0);
    tbl[11] = mk(0, ALU_SUB,  32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0);
    order = '{0, 1, 0, 1};

    m_vld = 1'b0; m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0; last_grant = -1;
    rst = 1'b1; perf_clr = 1'b0; rsp_ready = 1'b1;
    req_valid = 2'b11; req_src1 = '0; req_src2 = '0; req_sel = {ALU_ADD, ALU_ADD};
    cur_exp[0] = ref_alu(ALU_ADD, 0, 0);
    cur_exp[1] = ref_alu(ALU_ADD, 0, 0);
    @(negedge clk);

    // reset with both requesters valid
    cycle();
    cycle();
    chk("rst_rsp_res", rsp_res, 32'd0);
    chk("rst_rsp_is_0", rsp_is_0, 1'b0);
    chk("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);

    // fairness: alternating grants starting at requester 0
    rst = 1'b0;
    drive(0, ALU_ADD, 32'd5, 32'd3, '{32'd8, 1'b0, 1'b0, 0});
    drive(1, ALU_SUB, 32'd3, 32'd3, '{32'd0, 1'b1, 1'b0, 1});
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("grant_order", last_grant, order[k]);
    end

    // backpressure: stall three cycles, then accept+issue without a bubble
    req_valid = 2'b01;
    cycle();
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    repeat (3) cycle();
    rsp_ready = 1'b1;
    cycle();
    chk("no_bubble_vld", rsp_valid, 1'b1);
    chk("no_bubble_id", rsp_id, 1'b1);
    req_valid = 2'b00;
    cycle();

    // single-requester vector table
    for (int i = 0; i < 12; i++) begin
      req_valid = 2'b00;
      drive(tbl[i].req, tbl[i].sel, tbl[i].a, tbl[i].b,
            '{tbl[i].res, tbl[i].is0, tbl[i].err, tbl[i].req});
      cycle();
      chk("tbl_grant", last_grant, tbl[i].req);
    end
    req_valid = 2'b00;
    cycle();

    // reset while a response is stalled
    drive(1, ALU_ADD, 32'd1, 32'd2, '{32'd3, 1'b0, 1'b0, 1});
    cycle();
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_drop", rsp_valid, 1'b0);
    cycle();
    rsp_ready = 1'b1;

    // random traffic with held requests
    for (int n = 0; n < 80; n++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          rs = aluop_sel_t'(4'($urandom_range(0, 15)));
          req_src1[i] = $urandom;
          req_src2[i] = $urandom;
          e = ref_alu(rs, req_src1[i], req_src2[i]);
          drive(i, rs, req_src1[i], req_src2[i], e);
        end
      end
      cycle();
      if (last_grant >= 0) req_valid[last_grant] = 1'b0;
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (2) cycle();

`ifdef ALU_ARB_PERF_EN
    perf_clr = 1'b1;
    cycle();
    perf_clr = 1'b0;
    drive(1, ALU_ADD, 32'd1, 32'd1, '{32'd2, 1'b0, 1'b0, 1});
    repeat (10) cycle();
    chk("cnt_10", grant_cnt[1], 4'd10);
    repeat (10) cycle();
    chk("cnt_sat", grant_cnt[1], 4'd15);
    perf_clr = 1'b1;
    cycle();
    chk("cnt_clr", grant_cnt[1], 4'd0);
    perf_clr = 1'b0;
    req_valid = 2'b00;
    repeat (2) cycle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
